// File: rtl/onchip_ram_pkg.sv
// Shared types, limits and parameter legality check for the pipelined Avalon-MM on-chip RAM.
package onchip_ram_pkg;

   typedef enum logic {CLEAR, READY} ram_state_t;

   localparam int MAX_READ_LATENCY = 2;
   localparam int MIN_DATA_WIDTH   = 8;

   function automatic bit params_legal(input int data_width, input int depth,
                                       input int addr_width, input int read_latency,
                                       input int init_zero);
      return (data_width % 8 == 0) && (data_width >= MIN_DATA_WIDTH) && (data_width <= 128)
          && (depth >= 2) && (depth <= 65536) && (addr_width == $clog2(depth))
          && (read_latency >= 1) && (read_latency <= MAX_READ_LATENCY)
          && ((init_zero == 0) || (init_zero == 1));
   endfunction

endpackage

// File: rtl/onchip_ram_core.sv
// Byte-enabled single-port RAM with clock enable; read data registered only on read strobes.
module onchip_ram_core
   import onchip_ram_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 256,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                    clk_i,
   input  logic                    ce_i,
   input  logic                    we_i,
   input  logic                    re_i,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   output logic [DATA_WIDTH-1:0]   rdata_o
);

   localparam int LANES = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (ce_i && we_i) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            if (be_i[i]) mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
         end
      end
      if (ce_i && re_i) rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/onchip_ram_avmm_pipelined.sv
// Avalon-MM RAM slave: zero-clear sweep FSM, accept/range logic and 1- or 2-cycle read pipeline.
module onchip_ram_avmm_pipelined
   import onchip_ram_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH        = 256,
   parameter int ADDR_WIDTH   = $clog2(DEPTH),
   parameter int READ_LATENCY = 1,
   parameter int INIT_ZERO    = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [ADDR_WIDTH-1:0]   address,
   input  logic [DATA_WIDTH/8-1:0] byteenable,
   input  logic                    chipselect,
   input  logic                    read,
   input  logic                    write,
   input  logic [DATA_WIDTH-1:0]   writedata,
   input  logic                    clken,
   input  logic                    reset_req,
   output logic [DATA_WIDTH-1:0]   readdata,
   output logic                    readdatavalid,
   output logic                    waitrequest,
   output logic                    init_done
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   if (!params_legal(DATA_WIDTH, DEPTH, ADDR_WIDTH, READ_LATENCY, INIT_ZERO)) begin : g_param_err
      $error("onchip_ram_avmm_pipelined: illegal parameter combination");
   end

   ram_state_t state_q, state_d;
   logic [ADDR_WIDTH-1:0]   sweep_q, sweep_d;
   logic                    en, acc, wr_acc, rd_acc, in_range;
   logic                    ram_ce, ram_we, ram_re;
   logic [ADDR_WIDTH-1:0]   ram_addr;
   logic [DATA_WIDTH/8-1:0] ram_be;
   logic [DATA_WIDTH-1:0]   ram_wdata, ram_rdata, d1, rd_out;
   logic                    v1_q, oor1_q, v_out;

   assign en       = clken & ~reset_req;
   assign in_range = 32'(address) < 32'(DEPTH);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= (INIT_ZERO != 0) ? CLEAR : READY;
         sweep_q <= '0;
      end else if (en) begin
         state_q <= state_d;
         sweep_q <= sweep_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      case (state_q)
         CLEAR: begin
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == LAST_ADDR) begin
               state_d = READY;
               sweep_d = '0;
            end
         end
         READY: ;
      endcase
   end

   always_comb begin
      waitrequest = reset | ~en | (state_q != READY);
      init_done   = ~reset & (state_q == READY);
   end

   assign acc    = chipselect & (read | write) & ~waitrequest;
   assign wr_acc = acc & write;
   assign rd_acc = acc & read & ~write;

   // Out-of-range reads go to word 0 so the RAM is never indexed past DEPTH; oor1_q zeroes the result.
   always_comb begin
      ram_ce = en & ~reset;
      if (state_q == CLEAR) begin
         ram_addr  = sweep_q;
         ram_be    = '1;
         ram_wdata = '0;
         ram_we    = 1'b1;
         ram_re    = 1'b0;
      end else begin
         ram_addr  = in_range ? address : '0;
         ram_be    = byteenable;
         ram_wdata = writedata;
         ram_we    = wr_acc & in_range;
         ram_re    = rd_acc;
      end
   end

   onchip_ram_core #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_core (
      .clk_i   (clk),
      .ce_i    (ram_ce),
      .we_i    (ram_we),
      .re_i    (ram_re),
      .addr_i  (ram_addr),
      .be_i    (ram_be),
      .wdata_i (ram_wdata),
      .rdata_o (ram_rdata)
   );

   // oor1_q powers up set so readdata reads 0 after reset until the first accepted read.
   always_ff @(posedge clk) begin
      if (reset) begin
         v1_q   <= 1'b0;
         oor1_q <= 1'b1;
      end else if (en) begin
         v1_q <= rd_acc;
         if (rd_acc) oor1_q <= ~in_range;
      end
   end

   assign d1 = oor1_q ? '0 : ram_rdata;

   if (READ_LATENCY == 2) begin : g_lat2
      logic                  v2_q;
      logic [DATA_WIDTH-1:0] data2_q;

      always_ff @(posedge clk) begin
         if (reset) begin
            v2_q    <= 1'b0;
            data2_q <= '0;
         end else if (en) begin
            v2_q <= v1_q;
            if (v1_q) data2_q <= d1;
         end
      end

      assign v_out  = v2_q;
      assign rd_out = data2_q;
   end else begin : g_lat1
      assign v_out  = v1_q;
      assign rd_out = d1;
   end

   assign readdata      = reset ? '0 : rd_out;
   assign readdatavalid = v_out & en & ~reset;

endmodule

// File: tb/tb_onchip_ram_avmm_pipelined.sv
// Scoreboard bench: dut0 DEPTH=8/latency 1, dut1 DEPTH=6/latency 2, directed vectors.
module tb_onchip_ram_avmm_pipelined;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] due;
   } exp_t;

   logic        clk = 1'b0;
   logic [1:0]  rst_s, clken_s, rreq_s, cs_s, rd_s, wr_s;
   logic [2:0]  addr_s [2];
   logic [3:0]  be_s   [2];
   logic [31:0] wd_s   [2];
   logic [31:0] rdata_o [2];
   logic [1:0]  rdv_o, wait_o, done_o;

   logic [31:0] cyc = 0;
   int          checks = 0;
   int          errors = 0;
   exp_t        q0[$];
   exp_t        q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   onchip_ram_avmm_pipelined #(
      .DATA_WIDTH (32), .DEPTH (8), .READ_LATENCY (1), .INIT_ZERO (1)
   ) u_dut0 (
      .clk (clk), .reset (rst_s[0]), .address (addr_s[0]), .byteenable (be_s[0]),
      .chipselect (cs_s[0]), .read (rd_s[0]), .write (wr_s[0]), .writedata (wd_s[0]),
      .clken (clken_s[0]), .reset_req (rreq_s[0]), .readdata (rdata_o[0]),
      .readdatavalid (rdv_o[0]), .waitrequest (wait_o[0]), .init_done (done_o[0])
   );

   onchip_ram_avmm_pipelined #(
      .DATA_WIDTH (32), .DEPTH (6), .READ_LATENCY (2), .INIT_ZERO (1)
   ) u_dut1 (
      .clk (clk), .reset (rst_s[1]), .address (addr_s[1]), .byteenable (be_s[1]),
      .chipselect (cs_s[1]), .read (rd_s[1]), .write (wr_s[1]), .writedata (wd_s[1]),
      .clken (clken_s[1]), .reset_req (rreq_s[1]), .readdata (rdata_o[1]),
      .readdatavalid (rdv_o[1]), .waitrequest (wait_o[1]), .init_done (done_o[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic mon(input int d);
      exp_t e;
      bit   empty;
      e = '0;
      if (d == 0) begin
         empty = (q0.size() == 0);
         if (!empty) e = q0.pop_front();
      end else begin
         empty = (q1.size() == 0);
         if (!empty) e = q1.pop_front();
      end
      if (empty) begin
         checks++;
         errors++;
         $display("FAIL dut%0d unexpected readdatavalid: cycle %0d data %h, expected no strobe",
                  d, cyc, rdata_o[d]);
      end else begin
         chk($sformatf("dut%0d readdata", d), rdata_o[d], e.data);
         chk($sformatf("dut%0d rdv cycle", d), cyc, e.due);
      end
   endtask

   always @(negedge clk) begin
      if (rdv_o[0] === 1'b1) mon(0);
      if (rdv_o[1] === 1'b1) mon(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic op(input int d, input bit cs, input bit r, input bit w,
                     input logic [2:0] a, input logic [3:0] be, input logic [31:0] wd);
      cs_s[d] = cs; rd_s[d] = r; wr_s[d] = w;
      addr_s[d] = a; be_s[d] = be; wd_s[d] = wd;
      step();
      cs_s[d] = 1'b0; rd_s[d] = 1'b0; wr_s[d] = 1'b0;
   endtask

   task automatic push(input int d, input logic [31:0] data, input logic [31:0] due);
      exp_t e;
      e.data = data;
      e.due  = due;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic rdx(input int d, input logic [2:0] a, input logic [31:0] exp);
      push(d, exp, cyc + ((d == 0) ? 32'd1 : 32'd2));
      op(d, 1'b1, 1'b1, 1'b0, a, 4'h0, 32'h0);
   endtask

   task automatic wrx(input int d, input logic [2:0] a, input logic [3:0] be, input logic [31:0] wd);
      op(d, 1'b1, 1'b0, 1'b1, a, be, wd);
   endtask

   initial begin
      rst_s = 2'b11; clken_s = 2'b11; rreq_s = 2'b00;
      cs_s = 2'b00; rd_s = 2'b00; wr_s = 2'b00;
      for (int i = 0; i < 2; i++) begin
         addr_s[i] = '0; be_s[i] = '0; wd_s[i] = '0;
      end

      // Reset state
      step();
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("dut%0d rst waitrequest", d), 32'(wait_o[d]), 32'd1);
         chk($sformatf("dut%0d rst init_done", d), 32'(done_o[d]), 32'd0);
         chk($sformatf("dut%0d rst readdatavalid", d), 32'(rdv_o[d]), 32'd0);
         chk($sformatf("dut%0d rst readdata", d), rdata_o[d], 32'h0);
      end
      step();
      rst_s = 2'b00;

      // Clear sweep: dut0 busy for 8 cycles, dut1 for 6
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("dut0 clear waitrequest", 32'(wait_o[0]), 32'd1);
         chk("dut0 clear init_done", 32'(done_o[0]), 32'd0);
         chk("dut1 clear init_done", 32'(done_o[1]), (i >= 6) ? 32'd1 : 32'd0);
         step();
      end
      #1;
      chk("dut0 ready init_done", 32'(done_o[0]), 32'd1);
      chk("dut0 ready waitrequest", 32'(wait_o[0]), 32'd0);

      // dut0: latency 1
      for (int a = 0; a < 8; a++) rdx(0, 3'(a), 32'h0);
      wrx(0, 3'd3, 4'b0101, 32'hAABBCCDD);
      rdx(0, 3'd3, 32'h00BB00DD);
      wrx(0, 3'd3, 4'b0000, 32'hFFFFFFFF);
      rdx(0, 3'd3, 32'h00BB00DD);
      wrx(0, 3'd3, 4'b1010, 32'h11223344);
      rdx(0, 3'd3, 32'h11BB33DD);
      op(0, 1'b1, 1'b1, 1'b1, 3'd5, 4'hF, 32'h55);
      rdx(0, 3'd5, 32'h55);
      op(0, 1'b0, 1'b1, 1'b0, 3'd5, 4'h0, 32'h0);
      wrx(0, 3'd7, 4'hF, 32'hCAFEF00D);
      rdx(0, 3'd7, 32'hCAFEF00D);
      push(0, 32'h55, cyc + 32'd3);
      cs_s[0] = 1'b1; rd_s[0] = 1'b1; addr_s[0] = 3'd5;
      step();
      cs_s[0] = 1'b0; rd_s[0] = 1'b0; clken_s[0] = 1'b0;
      idle(2);
      clken_s[0] = 1'b1;
      idle(3);

      // dut1: latency 2, DEPTH 6
      for (int a = 0; a < 4; a++) wrx(1, 3'(a), 4'hF, 32'h10 + 32'(a));
      for (int a = 0; a < 4; a++) rdx(1, 3'(a), 32'h10 + 32'(a));
      rdx(1, 3'd4, 32'h0);
      rdx(1, 3'd5, 32'h0);
      rdx(1, 3'd7, 32'h0);
      wrx(1, 3'd6, 4'hF, 32'hDEADBEEF);
      rdx(1, 3'd0, 32'h10);
      rdx(1, 3'd6, 32'h0);
      idle(3);

      // dut1 stall: read in flight, clken low 3 cycles, attempted write to same word
      push(1, 32'h12, cyc + 32'd5);
      cs_s[1] = 1'b1; rd_s[1] = 1'b1; addr_s[1] = 3'd2;
      step();
      rd_s[1] = 1'b0; wr_s[1] = 1'b1; be_s[1] = 4'hF; wd_s[1] = 32'hBAD0BAD0;
      clken_s[1] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("dut1 stall waitrequest", 32'(wait_o[1]), 32'd1);
         step();
      end
      clken_s[1] = 1'b1; cs_s[1] = 1'b0; wr_s[1] = 1'b0;
      idle(4);
      rdx(1, 3'd2, 32'h12);
      idle(3);

      // dut0: reset at sweep address 4 restarts the full sweep
      wrx(0, 3'd6, 4'hF, 32'h66);
      rdx(0, 3'd6, 32'h66);
      idle(2);
      rst_s[0] = 1'b1;
      step();
      rst_s[0] = 1'b0;
      idle(4);
      rst_s[0] = 1'b1;
      #1;
      chk("dut0 midsweep rst init_done", 32'(done_o[0]), 32'd0);
      step();
      rst_s[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("dut0 resweep waitrequest", 32'(wait_o[0]), 32'd1);
         chk("dut0 resweep init_done", 32'(done_o[0]), 32'd0);
         step();
      end
      #1;
      chk("dut0 resweep done", 32'(done_o[0]), 32'd1);
      rdx(0, 3'd6, 32'h0);
      rdx(0, 3'd3, 32'h0);

      // dut1: reset with two reads in flight
      op(1, 1'b1, 1'b1, 1'b0, 3'd0, 4'h0, 32'h0);
      op(1, 1'b1, 1'b1, 1'b0, 3'd1, 4'h0, 32'h0);
      rst_s[1] = 1'b1;
      step();
      rst_s[1] = 1'b0;
      idle(8);
      rdx(1, 3'd1, 32'h0);

      idle(6);
      chk("dut0 pending reads", 32'(q0.size()), 32'd0);
      chk("dut1 pending reads", 32'(q1.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/onchip_ram_avmm_pipelined.md
Name: onchip_ram_avmm_pipelined

Overview:
- Parametrised Avalon-MM on-chip RAM slave for the SoC fabric; next generation of the fixed 4x32 single-port on-chip memory.
- Generalises data width and depth. Adds a selectable read latency of 1 or 2 with `readdatavalid` signalling, and `waitrequest` back-pressure.
- Adds an optional post-reset zero-clear sequencer, so software sees deterministic contents without an init file.

Parameters:
- DATA_WIDTH, 32, word width in bits; multiple of 8, range 8..128.
- DEPTH, 256, number of words; any value 2..65536, need not be a power of 2.
- ADDR_WIDTH, $clog2(DEPTH), word address width; derived, not overridden.
- READ_LATENCY, 1, cycles from accepted read to `readdatavalid`; legal values 1 or 2.
- INIT_ZERO, 1, 1 = clear every word to 0 after each reset; 0 = contents undefined after reset.

Ports:
- clk, in, 1, single clock domain.
- reset, in, 1, synchronous, active-high.
- address, in, ADDR_WIDTH, word address.
- byteenable, in, DATA_WIDTH/8, per-byte write mask.
- chipselect, in, 1, slave select.
- read, in, 1, read request.
- write, in, 1, write request.
- writedata, in, DATA_WIDTH, write data.
- clken, in, 1, global clock enable; low freezes the block.
- reset_req, in, 1, reset-pending hint; high freezes the block, same effect as clken low.
- readdata, out, DATA_WIDTH, read data.
- readdatavalid, out, 1, one-cycle strobe qualifying readdata.
- waitrequest, out, 1, transfer not accepted this cycle.
- init_done, out, 1, high once the block is in READY state.

Behaviour:
- Reset: one clock and reset only; reset is synchronous and active-high. While reset=1: readdata=0, readdatavalid=0, waitrequest=1, init_done=0, read pipeline flushed. Reset has priority over all other inputs.
- Enable: en = clken & ~reset_req. When en=0, the FSM, sweep counter, read pipeline and RAM all hold; no write occurs; waitrequest=1. readdatavalid is held at 0 during the frozen cycles and resumes on the first en=1 cycle.
- FSM states: CLEAR, READY.
  - After reset, enter CLEAR if INIT_ZERO=1, otherwise READY.
  - CLEAR: on each en cycle, write 0 to sweep_addr with all byte lanes enabled, then increment sweep_addr. Start at 0; on DEPTH-1 go to READY.
  - CLEAR takes exactly DEPTH enabled cycles; waitrequest=1 throughout.
  - READY: init_done=1; waitrequest = ~en.
  - Reset asserted mid-sweep restarts the sweep at address 0.
- Accept: acc = chipselect & (read | write) & ~waitrequest.
  - If read and write are both high, the write wins and no readdatavalid is produced.
  - A write updates only the lanes with byteenable[i]=1; byteenable=0 is a no-op but still accepted.
  - A read with chipselect=0 is ignored.
- Read latency: an accepted read at cycle T gives readdatavalid=1 with the data at T+READ_LATENCY, counting enabled cycles only.
  - Pipelined: one read per cycle, back-to-back, no bubbles.
  - READ_LATENCY=2 adds an output register stage.
- Ordering: a read accepted in the cycle after a write to the same address returns the new data. A read never observes a write accepted in the same or a later cycle.
- Range: address >= DEPTH (only when DEPTH is not a power of 2): writes are dropped; reads are accepted and return 0 with readdatavalid.
- readdata holds its last value when readdatavalid=0.
- Reset mid-read: in-flight reads are discarded; no readdatavalid after reset.

Decomposition:
- Package onchip_ram_pkg holds:
  - typedef enum {CLEAR, READY} ram_state_t;
  - constants MAX_READ_LATENCY=2 and MIN_DATA_WIDTH=8;
  - a function checking parameter legality, asserted at elaboration.
- Sub-module onchip_ram_core: inferred byte-enabled single-port RAM (DATA_WIDTH x DEPTH) with a clock enable.
  - The top level holds the FSM, sweep counter, accept logic, latency pipeline and range check.

Test Plan:
- Clear sequence: INIT_ZERO=1, DEPTH=8, reset for 2 cycles -> waitrequest=1 and init_done=0 for exactly 8 cycles, then init_done=1. Reads of addresses 0..7 all return 0x00000000.
- Byte-enable write: write 0xAABBCCDD to addr 3 with be=4'b0101, then read addr 3 -> readdata=0x00BB00DD at T+READ_LATENCY.
- Back-to-back reads: READ_LATENCY=2, addresses 0..3 preloaded with 0x10..0x13, reads on 4 consecutive cycles -> readdatavalid high for 4 consecutive cycles starting at T+2, data 0x10..0x13 in order.
- Stall: clken low for 3 cycles while a read is in flight (latency 2) -> readdatavalid delayed by exactly 3 cycles with data unchanged; a write issued during the stall is not accepted (waitrequest=1) and memory is unchanged.
- Conflict and range: read=write=1 to addr 5 with data 0x55 -> no readdatavalid; a next-cycle read returns 0x55. DEPTH=6, read addr 7 -> readdatavalid with readdata=0.
- Reset mid-operation: reset at sweep address 4 -> the sweep restarts at 0 and init_done is delayed by the full DEPTH cycles. Reset with 2 reads in flight -> no readdatavalid is emitted afterwards.
